// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: arbiter state type and default sizing, shared with the interconnect muxes.
package wb_arb_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
    localparam int ARB_NM = 8;
    localparam int ARB_GW = $clog2(ARB_NM);
    localparam int ARB_WDOG_CYC = 1024;
    localparam int ARB_WDOG_W = $clog2(ARB_WDOG_CYC);
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: rotate-priority encoder, first request after i_last (wrapping), optionally masking one index.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = ARB_NM,
    parameter int GW = ARB_GW
) (
    input  logic [NM-1:0] i_req,
    input  logic [GW-1:0] i_last,
    input  logic          i_mask_en,
    input  logic [GW-1:0] i_mask_idx,
    output logic          o_any,
    output logic [GW-1:0] o_idx
);
    logic [NM-1:0] w_req;
    logic [GW-1:0] w_j;
    assign w_req = i_req & ~(i_mask_en ? (NM'(1) << i_mask_idx) : '0);
    // Walk the rotation backwards so the nearest candidate is written last.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_j = '0;
        for (int i = NM; i >= 1; i--) begin
            w_j = GW'((int'(i_last) + i) % NM);
            if (w_req[w_j]) begin
                o_any = 1'b1;
                o_idx = w_j;
            end
        end
    end
endmodule

// File: rtl/wb_rr_arb.sv
// wb_rr_arb: round-robin Wishbone bus arbiter holding grant for the whole cycle.
// Define ARB_WATCHDOG_EN to enable the hung-transfer watchdog (wdog_err_o).
module wb_rr_arb
    import wb_arb_pkg::*;
#(
    parameter int NM       = ARB_NM,
    parameter int GW       = ARB_GW,
    parameter int WDOG_CYC = ARB_WDOG_CYC,
    parameter int WDOG_W   = ARB_WDOG_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [NM-1:0] req_i,
    input  logic          ack_i,
    output logic [GW-1:0] gnt_o,
    output logic          gnt_vld_o,
    output logic          wdog_err_o
);
    arb_state_t    r_state, w_state;
    logic [GW-1:0] r_gnt, w_gnt, r_last, w_last, w_pick;
    logic          w_any, w_hold;
    assign w_hold = (r_state == GRANT) && req_i[r_gnt];
    wb_rr_pick #(.NM(NM), .GW(GW)) u_pick (
        .i_req      (req_i),
        .i_last     (r_last),
        .i_mask_en  (r_state == GRANT),
        .i_mask_idx (r_gnt),
        .o_any      (w_any),
        .o_idx      (w_pick)
    );
    always_comb begin
        w_state = r_state;
        w_gnt = r_gnt;
        w_last = r_last;
        if (!w_hold) begin
            w_state = w_any ? GRANT : IDLE;
            w_gnt = w_any ? w_pick : r_gnt;
            w_last = w_any ? w_pick : r_last;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt <= '0;
            r_last <= GW'(NM - 1);
        end else begin
            r_state <= w_state;
            r_gnt <= w_gnt;
            r_last <= w_last;
        end
    end
    assign gnt_o = r_gnt;
    assign gnt_vld_o = (r_state == GRANT);
`ifdef ARB_WATCHDOG_EN
    logic [WDOG_W-1:0] r_cnt;
    logic              r_wdog_err, w_expire;
    // Ack in the expiry cycle wins; counting only continues while the same grant is held.
    assign w_expire = (r_state == GRANT) && !ack_i && (r_cnt == WDOG_W'(WDOG_CYC - 1));
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_err <= w_expire;
            r_cnt <= (w_hold && !ack_i && !w_expire) ? r_cnt + 1'b1 : '0;
        end
    end
    assign wdog_err_o = r_wdog_err;
`else
    logic w_unused;
    assign w_unused = ^{ack_i, WDOG_W'(WDOG_CYC)};
    assign wdog_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_rr_arb.sv
// tb_wb_rr_arb: directed and random checks of wb_rr_arb against a rotation-order reference model.
module tb_wb_rr_arb;
    localparam int NM = 8;
    localparam int GW = 3;
    localparam int WDOG_CYC = 16;
    localparam int WDOG_W = 4;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic          clk_i = 1'b0;
    logic          rst_i, ack_i;
    logic [NM-1:0] req_i;
    logic [GW-1:0] gnt_o;
    logic          gnt_vld_o, wdog_err_o;
    int n_chk = 0;
    int n_pass = 0;
    bit m_vld, m_err;
    int m_gnt, m_last, m_wait;

    always #5 clk_i = ~clk_i;

    wb_rr_arb #(.NM(NM), .GW(GW), .WDOG_CYC(WDOG_CYC), .WDOG_W(WDOG_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .ack_i      (ack_i),
        .gnt_o      (gnt_o),
        .gnt_vld_o  (gnt_vld_o),
        .wdog_err_o (wdog_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_vld = 1'b0;
        m_err = 1'b0;
        m_gnt = 0;
        m_last = NM - 1;
        m_wait = 0;
    endtask

    // Grant rules: keep the owner while it requests, otherwise the next requester in rotation after the last grant.
    task automatic model_step(input logic [NM-1:0] r, input bit a);
        bit exp_err;
        int nxt, idx;
        exp_err = WD && m_vld && !a && (m_wait == WDOG_CYC - 1);
        if (m_vld && r[m_gnt[GW-1:0]]) begin
            m_wait = (a || exp_err) ? 0 : m_wait + 1;
        end else begin
            nxt = -1;
            for (int k = 1; k <= NM && nxt < 0; k++) begin
                idx = (m_last + k) % NM;
                if (r[idx[GW-1:0]]) nxt = idx;
            end
            m_vld = (nxt >= 0);
            if (m_vld) begin
                m_gnt = nxt;
                m_last = nxt;
            end
            m_wait = 0;
        end
        m_err = exp_err;
    endtask

    task automatic step(input logic [NM-1:0] r, input bit a);
        req_i = r;
        ack_i = a;
        model_step(r, a);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("gnt_vld", gnt_vld_o, m_vld);
        chk("gnt", gnt_o, m_gnt);
        chk("wdog", wdog_err_o, m_err);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = '0;
        ack_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_vld", gnt_vld_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_wdog", wdog_err_o, 0);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [NM-1:0] d;
        int first, pulses;
        rst_i = 1'b1;
        req_i = '0;
        ack_i = 1'b0;
        do_reset();
        repeat (10) step('0, 1'b0);
        step(8'h10, 1'b0);
        chk("pre_midrst_gnt", gnt_o, 4);
        step(8'h10, 1'b0);
        rst_i = 1'b1;
        #1;
        chk("midrst_vld", gnt_vld_o, 0);
        chk("midrst_gnt", gnt_o, 0);
        do_reset();

        step(8'h81, 1'b0);
        chk("t2_first", gnt_o, 0);
        step(8'h80, 1'b0);
        chk("t2_rot", gnt_o, 7);
        chk("t2_vld", gnt_vld_o, 1);
        step('0, 1'b0);

        do_reset();
        step(8'hFF, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk("t3_order", gnt_o, i % NM);
            chk("t3_vld", gnt_vld_o, 1);
            step(8'hFF, 1'b0);
            step(8'hFF, 1'b0);
            d = 8'hFF;
            d[i % NM] = 1'b0;
            step(d, 1'b0);
        end
        step('0, 1'b0);

        step(8'h04, 1'b0);
        chk("t4_gnt", gnt_o, 2);
        repeat (19) step(8'h04, 1'b0);
        step('0, 1'b0);
        chk("t4_idle", gnt_vld_o, 0);
        step(8'h04, 1'b0);
        chk("t4_regnt", gnt_o, 2);
        chk("t4_regnt_vld", gnt_vld_o, 1);
        step('0, 1'b0);

`ifdef ARB_WATCHDOG_EN
        step(8'h08, 1'b0);
        chk("t5_gnt", gnt_o, 3);
        first = 0;
        pulses = 0;
        for (int i = 1; i <= 31; i++) begin
            step(8'h08, 1'b0);
            if (wdog_err_o === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("t5_first", first, 16);
        chk("t5_pulses", pulses, 1);
        step('0, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 200; i++) begin
            step(8'h08, (i % 10) == 0);
            if (wdog_err_o !== 1'b0) pulses++;
        end
        chk("t6_no_pulse", pulses, 0);
`else
        pulses = 0;
        repeat (200) begin
            step(8'h08, 1'b0);
            if (wdog_err_o !== 1'b0) pulses++;
        end
        chk("t6_tied_off", pulses, 0);
`endif
        step('0, 1'b0);

        do_reset();
        repeat (400) begin
            d = NM'($urandom);
            if (m_vld && $urandom_range(3) != 0) d[m_gnt[GW-1:0]] = 1'b1;
            step(d, $urandom_range(7) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
